// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package parking_pkg;

  localparam int NUM_GATES_DEF = 4;
  localparam int COUNT_W       = 10;
  localparam int REJ_W         = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first requesting gate at or after rr_ptr.
// Latency: combinational.
// Backpressure: none; any_vld is low when no gate requests.
module rr_picker #(
  parameter int NUM_GATES = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_GATES-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [IDX_W-1:0]     winner,
  output logic                 any_vld
);

  always_comb begin
    int idx;
    logic [IDX_W-1:0] sel;
    idx     = 0;
    sel     = '0;
    winner  = '0;
    any_vld = 1'b0;
    for (int i = 0; i < NUM_GATES; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_GATES;
      sel = idx[IDX_W-1:0];
      if (!any_vld && req[sel]) begin
        any_vld = 1'b1;
        winner  = sel;
      end
    end
  end

endmodule

// File: rtl/gate_arbiter.sv
// Serialises entry/exit requests from NUM_GATES gates onto one Parking instance.
// Latency: gate_req rise to gate_done is 2 cycles; Parking pulses at least 3 cycles apart.
// Backpressure: gates hold gate_req until gate_done; a gate dropping early is skipped.
module gate_arbiter
  import parking_pkg::*;
#(
  parameter int NUM_GATES = NUM_GATES_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_GATES-1:0] gate_req,
  input  logic [NUM_GATES-1:0] gate_is_exit,
  input  logic [NUM_GATES-1:0] gate_is_uni,
  output logic [NUM_GATES-1:0] gate_done,
  output logic [NUM_GATES-1:0] gate_ok,
  input  logic [COUNT_W-1:0]   uni_parked_car,
  input  logic [COUNT_W-1:0]   free_parked_car,
  input  logic                 uni_is_vacated_space,
  input  logic                 free_is_vacated_space,
  output logic                 car_entered,
  output logic                 is_uni_car_entered,
  output logic                 car_exited,
  output logic                 is_uni_car_exited,
  output logic [REJ_W-1:0]     reject_count
);

  localparam int IDX_W = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GATES - 1);

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       winner_q, winner_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_vld;
  logic [NUM_GATES-1:0]   done_d, ok_d;
  logic                   entered_d, uni_entered_d, exited_d, uni_exited_d;
  logic [REJ_W-1:0]       rej_d;
  logic                   win_req, win_exit, win_uni, win_ok;

  rr_picker #(
    .NUM_GATES (NUM_GATES),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req     (gate_req),
    .rr_ptr  (rr_ptr_q),
    .winner  (pick_idx),
    .any_vld (pick_vld)
  );

  // Admission uses only Parking's live flags, so capacity changes need no local state.
  assign win_req  = gate_req[winner_q];
  assign win_exit = gate_is_exit[winner_q];
  assign win_uni  = gate_is_uni[winner_q];
  assign win_ok   = win_exit ? (win_uni ? (uni_parked_car != '0) : (free_parked_car != '0))
                             : (win_uni ? uni_is_vacated_space : free_is_vacated_space);

  always_comb begin
    state_d       = state_q;
    winner_d      = winner_q;
    rr_ptr_d      = rr_ptr_q;
    done_d        = '0;
    ok_d          = '0;
    entered_d     = 1'b0;
    uni_entered_d = 1'b0;
    exited_d      = 1'b0;
    uni_exited_d  = 1'b0;
    rej_d         = reject_count;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          winner_d = pick_idx;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        rr_ptr_d = (winner_q == LAST_IDX) ? '0 : winner_q + IDX_W'(1);
        if (!win_req) begin
          state_d = IDLE;
        end else begin
          state_d          = SETTLE;
          done_d[winner_q] = 1'b1;
          ok_d[winner_q]   = win_ok;
          if (win_ok && win_exit) begin
            exited_d     = 1'b1;
            uni_exited_d = win_uni;
          end else if (win_ok) begin
            entered_d     = 1'b1;
            uni_entered_d = win_uni;
          end else if (reject_count != '1) begin
            rej_d = reject_count + REJ_W'(1);
          end
        end
      end
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q            <= IDLE;
      winner_q           <= '0;
      rr_ptr_q           <= '0;
      gate_done          <= '0;
      gate_ok            <= '0;
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_exited  <= 1'b0;
      reject_count       <= '0;
    end else begin
      state_q            <= state_d;
      winner_q           <= winner_d;
      rr_ptr_q           <= rr_ptr_d;
      gate_done          <= done_d;
      gate_ok            <= ok_d;
      car_entered        <= entered_d;
      is_uni_car_entered <= uni_entered_d;
      car_exited         <= exited_d;
      is_uni_car_exited  <= uni_exited_d;
      reject_count       <= rej_d;
    end
  end

endmodule

// File: tb/tb_gate_arbiter.sv
// Directed bench for gate_arbiter: table of single-gate transactions plus corner sequences.
module tb_gate_arbiter;
  import parking_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] gate_req, gate_is_exit, gate_is_uni, gate_done, gate_ok;
  logic [9:0] uni_parked_car, free_parked_car;
  logic       uni_is_vacated_space, free_is_vacated_space;
  logic       car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic [7:0] reject_count;

  int checks   = 0;
  int failures = 0;

  gate_arbiter #(.NUM_GATES(4)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .gate_req              (gate_req),
    .gate_is_exit          (gate_is_exit),
    .gate_is_uni           (gate_is_uni),
    .gate_done             (gate_done),
    .gate_ok               (gate_ok),
    .uni_parked_car        (uni_parked_car),
    .free_parked_car       (free_parked_car),
    .uni_is_vacated_space  (uni_is_vacated_space),
    .free_is_vacated_space (free_is_vacated_space),
    .car_entered           (car_entered),
    .is_uni_car_entered    (is_uni_car_entered),
    .car_exited            (car_exited),
    .is_uni_car_exited     (is_uni_car_exited),
    .reject_count          (reject_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] req, is_exit, is_uni;
    logic [9:0] up, fp;
    logic       uvac, fvac;
    logic [3:0] exp_ok;
    logic       exp_ent, exp_uent, exp_ex, exp_uex;
    logic [7:0] exp_rej;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int pulses;
    logic [3:0] exp_done;

    // req  exit   uni   up    fp      uvac fvac ok     ent uent ex uex rej
    vecs[0] = '{4'b0001, 4'b0000, 4'b0001, 10'd0, 10'd0,   1'b1, 1'b0, 4'b0001, 1, 1, 0, 0, 8'd0};
    vecs[1] = '{4'b0010, 4'b0000, 4'b0000, 10'd0, 10'd0,   1'b0, 1'b1, 4'b0010, 1, 0, 0, 0, 8'd0};
    vecs[2] = '{4'b0100, 4'b0100, 4'b0000, 10'd5, 10'd0,   1'b1, 1'b1, 4'b0000, 0, 0, 0, 0, 8'd1};
    vecs[3] = '{4'b1000, 4'b1000, 4'b1000, 10'd3, 10'd0,   1'b0, 1'b0, 4'b1000, 0, 0, 1, 1, 8'd1};
    vecs[4] = '{4'b0001, 4'b0000, 4'b0000, 10'd0, 10'd0,   1'b1, 1'b0, 4'b0000, 0, 0, 0, 0, 8'd2};
    vecs[5] = '{4'b0010, 4'b0010, 4'b0000, 10'd0, 10'h200, 1'b0, 1'b0, 4'b0010, 0, 0, 1, 0, 8'd2};
    vecs[6] = '{4'b0100, 4'b0000, 4'b0100, 10'd0, 10'd0,   1'b0, 1'b1, 4'b0000, 0, 0, 0, 0, 8'd3};
    vecs[7] = '{4'b1000, 4'b1000, 4'b1000, 10'd0, 10'd7,   1'b1, 1'b1, 4'b0000, 0, 0, 0, 0, 8'd4};

    gate_req = '0; gate_is_exit = '0; gate_is_uni = '0;
    uni_parked_car = '0; free_parked_car = '0;
    uni_is_vacated_space = 1'b0; free_is_vacated_space = 1'b0;
    reset = 1'b1;
    step();
    step();
    check("rst_done", 32'(gate_done), 0);
    check("rst_ok", 32'(gate_ok), 0);
    check("rst_pulses", 32'({car_entered, is_uni_car_entered, car_exited, is_uni_car_exited}), 0);
    check("rst_reject", 32'(reject_count), 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      gate_req = vecs[i].req; gate_is_exit = vecs[i].is_exit; gate_is_uni = vecs[i].is_uni;
      uni_parked_car = vecs[i].up; free_parked_car = vecs[i].fp;
      uni_is_vacated_space = vecs[i].uvac; free_is_vacated_space = vecs[i].fvac;
      step();
      check($sformatf("v%0d_early_done", i), 32'(gate_done), 0);
      step();
      check($sformatf("v%0d_done", i), 32'(gate_done), 32'(vecs[i].req));
      check($sformatf("v%0d_ok", i), 32'(gate_ok), 32'(vecs[i].exp_ok));
      check($sformatf("v%0d_entered", i), 32'({car_entered, is_uni_car_entered}),
            32'({vecs[i].exp_ent, vecs[i].exp_uent}));
      check($sformatf("v%0d_exited", i), 32'({car_exited, is_uni_car_exited}),
            32'({vecs[i].exp_ex, vecs[i].exp_uex}));
      check($sformatf("v%0d_reject", i), 32'(reject_count), 32'(vecs[i].exp_rej));
      gate_req = '0;
      step();
      check($sformatf("v%0d_pulse_end", i), 32'({gate_done, car_entered, car_exited}), 0);
    end

    // All four gates held: grants 0,1,2,3,0 every 3 cycles.
    do_reset();
    gate_req = 4'b1111; gate_is_exit = '0; gate_is_uni = '0;
    free_is_vacated_space = 1'b1;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      step();
      exp_done = 4'b0000;
      if (cyc >= 2 && (cyc - 2) % 3 == 0) exp_done = 4'b0001 << (((cyc - 2) / 3) % 4);
      check($sformatf("rr_done_c%0d", cyc), 32'(gate_done), 32'(exp_done));
      check($sformatf("rr_pulse_c%0d", cyc), 32'({car_entered, car_exited}), 32'({|exp_done, 1'b0}));
    end
    gate_req = '0;

    // Gate 2 wins then drops: abort, gate 3 served next.
    do_reset();
    gate_req = 4'b1100; gate_is_exit = '0; gate_is_uni = 4'b1000;
    uni_is_vacated_space = 1'b1; free_is_vacated_space = 1'b1;
    step();
    gate_req = 4'b1000;
    step();
    check("abort_done", 32'(gate_done), 0);
    check("abort_pulse", 32'({car_entered, car_exited}), 0);
    check("abort_reject", 32'(reject_count), 0);
    step();
    check("abort_idle_done", 32'(gate_done), 0);
    step();
    check("abort_next_done", 32'(gate_done), 32'(4'b1000));
    check("abort_next_ok", 32'(gate_ok), 32'(4'b1000));
    check("abort_next_ent", 32'({car_entered, is_uni_car_entered}), 32'(2'b11));
    gate_req = '0;
    step();

    // Reset during ISSUE: the pending grant must not appear.
    do_reset();
    gate_req = 4'b0010; gate_is_exit = '0; gate_is_uni = '0;
    free_is_vacated_space = 1'b1;
    step();
    reset = 1'b1;
    step();
    check("rstiss_done", 32'(gate_done), 0);
    check("rstiss_ok", 32'(gate_ok), 0);
    check("rstiss_pulse", 32'({car_entered, is_uni_car_entered, car_exited, is_uni_car_exited}), 0);
    check("rstiss_rr_ptr", 32'(dut.rr_ptr_q), 0);
    check("rstiss_state", 32'(dut.state_q), 32'(IDLE));
    reset = 1'b0;
    gate_req = 4'b0011;
    step();
    step();
    check("rstiss_next_done", 32'(gate_done), 32'(4'b0001));
    gate_req = '0;
    step();

    // 300 free exits from an empty lot: counter sticks at 255.
    do_reset();
    gate_req = 4'b0001; gate_is_exit = 4'b0001; gate_is_uni = '0;
    free_parked_car = '0; uni_parked_car = 10'd9;
    pulses = 0;
    for (int cyc = 0; cyc < 1000 && pulses < 300; cyc++) begin
      step();
      if (gate_done[0]) begin
        pulses++;
        check($sformatf("sat_count_p%0d", pulses), 32'(reject_count),
              (pulses > 255) ? 255 : pulses);
        if (pulses == 300) begin
          check("sat_ok", 32'(gate_ok), 0);
          check("sat_exited", 32'(car_exited), 0);
        end
      end
    end
    check("sat_pulses_seen", pulses, 300);
    gate_req = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_arbiter.md
GATE_ARBITER -- requirements
Module: gate_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_GATES, default 4, giving the number of physical gates (entry or exit) sharing one Parking instance.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port gate_req, input, NUM_GATES bits: the gate has a car waiting; the gate holds it high until it receives gate_done.
REQ-005 The block SHALL have port gate_is_exit, input, NUM_GATES bits: 1 = exit request, 0 = entry request; stable while gate_req is high.
REQ-006 The block SHALL have port gate_is_uni, input, NUM_GATES bits: 1 = uni car, 0 = free car; stable while gate_req is high.
REQ-007 The block SHALL have port gate_done, output, NUM_GATES bits: a one-cycle pulse marking that the gate's request is resolved.
REQ-008 The block SHALL have port gate_ok, output, NUM_GATES bits: valid with gate_done; 1 = barrier opens, 0 = rejected.
REQ-009 The block SHALL have ports uni_parked_car and free_parked_car, input, 10 bits each, driven from Parking.
REQ-010 The block SHALL have ports uni_is_vacated_space and free_is_vacated_space, input, 1 bit each, driven from Parking.
REQ-011 The block SHALL have ports car_entered, is_uni_car_entered, car_exited and is_uni_car_exited, output, 1 bit each, driving the Parking inputs of the same names.
REQ-012 The block SHALL have port reject_count, output, 8 bits: number of rejected requests.

Function
REQ-013 The FSM SHALL have three states, IDLE, ISSUE and SETTLE, with IDLE as the reset state.
REQ-014 In IDLE, when any gate_req bit is 1, the block SHALL choose a winner round-robin, starting at the gate after the last winner (rr_ptr), register it, and move to ISSUE the next cycle.
REQ-015 Admission in ISSUE SHALL be computed from the registered winner: an entry is ok if the matching *_is_vacated_space is 1; an exit is ok if the matching *_parked_car is nonzero.
REQ-016 In ISSUE with ok=1, the block SHALL pulse exactly one of car_entered or car_exited for exactly one cycle, with the matching is_uni_* bit equal to gate_is_uni of the winner.
REQ-017 In ISSUE, the block SHALL pulse gate_done[winner] with gate_ok[winner]=ok for one cycle, then go to SETTLE.
REQ-018 In ISSUE with ok=0, the block SHALL pulse no Parking input and SHALL increment reject_count, saturating at 255.
REQ-019 SETTLE SHALL last exactly one cycle, so the Parking counts reflect the issued pulse, and SHALL then return to IDLE.
REQ-020 rr_ptr SHALL advance to winner+1 modulo NUM_GATES when leaving ISSUE.
REQ-021 The latency from a gate_req rise (arbiter idle, gate wins) to gate_done SHALL be 2 cycles, and the minimum time between two issued Parking pulses SHALL be 3 cycles.
REQ-022 The block SHALL never assert car_entered and car_exited in the same cycle, nor either one outside ISSUE.
REQ-023 If the winner's gate_req drops before ISSUE, the block SHALL abort: no Parking pulse, no gate_done, no reject_count change, and a return to IDLE with rr_ptr advanced.
REQ-024 Parking saturation and capacity changes, including the hourly growth of free capacity, SHALL be handled only through the vacated-space flags; the block SHALL hold no capacity constants.

Reset
REQ-025 While reset is high, the block SHALL hold state=IDLE, rr_ptr=0, reset_count=0 for reject_count, and all gate_done, gate_ok, car_* and is_uni_* outputs at 0.
REQ-026 A reset asserted in ISSUE or SETTLE SHALL take effect at the next edge; a pulse registered that same edge SHALL NOT appear.

Structure
REQ-027 Package parking_pkg SHALL hold the NUM_GATES default, the FSM state type, and the count width of 10.
REQ-028 A single sub-module, rr_picker, SHALL be combinational and SHALL map (gate_req, rr_ptr) to a winner index and an any-valid flag.
REQ-029 All outputs of gate_arbiter SHALL be registered.

Verification
REQ-030 With reset, then gate_req=0001, is_exit=0, is_uni=1, uni space=1: the bench SHALL see car_entered=1 and is_uni_car_entered=1 at cycle 2 after the request, plus gate_done[0]=1 and gate_ok[0]=1.
REQ-031 With gate_req=1111 held: the bench SHALL see grants in the order 0,1,2,3,0, one every 3 cycles.
REQ-032 With a free exit request and free_parked_car=0: the bench SHALL see gate_ok=0, no car_exited pulse, and reject_count=1.
REQ-033 With 300 rejects: the bench SHALL see reject_count stick at 255.
REQ-034 With gate 2 dropping its request in the cycle after it wins: the bench SHALL see no pulse and no gate_done, and gate 3 served next.
REQ-035 With reset asserted during ISSUE: the bench SHALL see all outputs at 0 the next cycle and rr_ptr=0.
